// File: rtl/memory_reg_pkg.sv
// Shared definitions for the memory register queue: default sizing, depth helper, error flags.
// Optional pass-through behaviour is selected with MEMORY_REG_FIFO_BYPASS_EN.
package memory_reg_pkg;

    localparam int DEFAULT_W = 8;
    localparam int DEFAULT_D = 2;

    function automatic int depth(input int d);
        return 1 << d;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/memory_reg_fifo_ctrl.sv
// Bookkeeping for the memory register queue: pointers, occupancy, full/empty and sticky errors.
// With MEMORY_REG_FIFO_BYPASS_EN defined, a push+pop into an empty queue is a pure pass-through.
module memory_reg_fifo_ctrl
    import memory_reg_pkg::*;
#(
    parameter int D = DEFAULT_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         write_en,
    input  logic         read_en,
    output logic [D-1:0] wr_ptr,
    output logic [D-1:0] rd_ptr,
    output logic [D:0]   count,
    output logic         full,
    output logic         empty,
    output logic         store_en,
    output fifo_err_t    err
);

    localparam logic [D:0] DEPTH_CNT = {1'b1, {D{1'b0}}};

    logic [D-1:0] wr_ptr_q, wr_ptr_d;
    logic [D-1:0] rd_ptr_q, rd_ptr_d;
    logic [D:0]   count_q, count_d;
    fifo_err_t    err_q, err_d;

    logic pass_through;
    logic push_ok;
    logic pop_ok;

    // Push/pop are single-cycle strobes. A push is taken when WriteEn is high and
    // there is room, or a same-cycle pop frees the slot; a pop is taken when ReadEn
    // is high and the queue holds data. Refused strobes only raise the sticky flags.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DEPTH_CNT);
`ifdef MEMORY_REG_FIFO_BYPASS_EN
        pass_through = empty && write_en && read_en;
`else
        pass_through = 1'b0;
`endif
        push_ok  = write_en && (!full || read_en) && !pass_through;
        pop_ok   = read_en && !empty;
        store_en = push_ok && !clear;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + D'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + D'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (D+1)'(1);
                2'b01:   count_d = count_q - (D+1)'(1);
                default: count_d = count_q;
            endcase
            if (write_en && full && !read_en) begin
                err_d.overflow = 1'b1;
            end
            if (read_en && empty && !pass_through) begin
                err_d.underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign err    = err_q;

endmodule

// File: rtl/memory_reg_fifo.sv
// W-bit, 2**D-entry register queue staging data between memory and datapath; head on DataOut.
// Define MEMORY_REG_FIFO_BYPASS_EN to let an incoming word appear on DataOut while empty.
module memory_reg_fifo
    import memory_reg_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int D = DEFAULT_D
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         WriteEn,
    input  logic [W-1:0] DataIn,
    input  logic         ReadEn,
    output logic [W-1:0] DataOut,
    output logic         Empty,
    output logic         Full,
    output logic [D:0]   Count,
    output logic         Overflow,
    output logic         Underflow
);

    localparam int DEPTH = depth(D);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    logic [D-1:0] wr_ptr;
    logic [D-1:0] rd_ptr;
    logic         store_en;
    fifo_err_t    err;

    memory_reg_fifo_ctrl #(
        .D(D)
    ) u_ctrl (
        .clk      (Clk),
        .rst      (Reset),
        .clear    (Clear),
        .write_en (WriteEn),
        .read_en  (ReadEn),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (Count),
        .full     (Full),
        .empty    (Empty),
        .store_en (store_en),
        .err      (err)
    );

    always_comb begin
        mem_d = mem_q;
        if (store_en) begin
            mem_d[wr_ptr] = DataIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Stale storage is masked while empty so a drained queue always reads as zero.
    always_comb begin
`ifdef MEMORY_REG_FIFO_BYPASS_EN
        if (Empty && WriteEn) begin
            DataOut = DataIn;
        end else if (Empty) begin
            DataOut = '0;
        end else begin
            DataOut = mem_q[rd_ptr];
        end
`else
        if (Empty) begin
            DataOut = '0;
        end else begin
            DataOut = mem_q[rd_ptr];
        end
`endif
    end

    assign Overflow  = err.overflow;
    assign Underflow = err.underflow;

endmodule
